weight_3_3_load_ctrl: RTL and testbench

WEIGHT_3_3_LOAD_CTRL -- requirements
Module: weight_3_3_load_ctrl

---
 rtl/weight_3_3_load_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_weight_3_3_load_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_3_3_load_ctrl.sv
// Weight load/read controller for a 3x3 bank of weight RAMs.
// Streams 9*cfg_load_words beats into nine RAMs (three per lane), then issues
// cfg_read_passes sweeps of cfg_read_len read addresses and tracks read latency.
module weight_3_3_load_ctrl #(
  parameter int KERNEL_NUM          = 9,
  parameter int WIDTH_RAM_ADDR_SIZE = 13,
  parameter int DATA_W              = 128,
  parameter int RAM_LAT             = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start,
  input  logic [WIDTH_RAM_ADDR_SIZE-1:0] cfg_load_words,
  input  logic [WIDTH_RAM_ADDR_SIZE-1:0] cfg_read_len,
  input  logic [7:0]                     cfg_read_passes,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [DATA_W-1:0]              weight_data_One,
  output logic [DATA_W-1:0]              weight_data_Two,
  output logic [DATA_W-1:0]              weight_data_Three,
  output logic [KERNEL_NUM-1:0]          weight_wr,
  output logic [WIDTH_RAM_ADDR_SIZE-1:0] weight_addra,
  output logic [WIDTH_RAM_ADDR_SIZE-1:0] weight_addrb,
  output logic                           rd_valid,
  output logic                           busy,
  output logic                           load_done,
  output logic                           done
);

  localparam int AW = WIDTH_RAM_ADDR_SIZE;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  logic [2:0]         state;
  logic [AW-1:0]      load_words_q;
  logic [AW-1:0]      read_len_q;
  logic [7:0]         read_passes_q;
  logic [3:0]         k;
  logic [AW-1:0]      wa;
  logic [AW-1:0]      rd_addr;
  logic [7:0]         pass_cnt;
  logic [2:0]         drain_cnt;
  logic [RAM_LAT-1:0] rd_pipe;

  logic accept;
  logic last_beat;
  logic last_addr;
  logic last_pass;
  logic issue;

  // Handshake, final-beat and end-of-sweep decodes
  always_comb begin
    accept    = s_valid && (state == LOAD);
    last_beat = accept && (k == 4'd8) && (wa == load_words_q - AW'(1));
    last_addr = (rd_addr == read_len_q - AW'(1));
    last_pass = (pass_cnt == read_passes_q - 8'd1);
    issue     = (state == READ);
  end

  assign s_ready      = (state == LOAD);
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign weight_addrb = rd_addr;
  assign rd_valid     = rd_pipe[RAM_LAT-1];

  // Control FSM with cfg latching and the k/wa/read/pass/drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      load_words_q  <= '0;
      read_len_q    <= '0;
      read_passes_q <= '0;
      k             <= '0;
      wa            <= '0;
      rd_addr       <= '0;
      pass_cnt      <= '0;
      drain_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            load_words_q  <= cfg_load_words;
            read_len_q    <= cfg_read_len;
            read_passes_q <= cfg_read_passes;
            k             <= '0;
            wa            <= '0;
            rd_addr       <= '0;
            pass_cnt      <= '0;
            state         <= (cfg_load_words == '0) ? GAP : LOAD;
          end
        end
        LOAD: begin
          if (last_beat) begin
            // Clear instead of incrementing so wa never steps past the final compare
            k     <= '0;
            wa    <= '0;
            state <= GAP;
          end else if (accept) begin
            if (k == 4'd8) begin
              k  <= '0;
              wa <= wa + AW'(1);
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        GAP: begin
          drain_cnt <= '0;
          state     <= ((read_len_q == '0) || (read_passes_q == '0)) ? FIN : READ;
        end
        READ: begin
          if (last_addr) begin
            rd_addr <= '0;
            if (last_pass) begin
              pass_cnt <= '0;
              state    <= DRAIN;
            end else begin
              pass_cnt <= pass_cnt + 8'd1;
            end
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(RAM_LAT - 1)) begin
            state <= FIN;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered write port: enable, address and per-lane data one cycle after a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_wr         <= '0;
      weight_addra      <= '0;
      weight_data_One   <= '0;
      weight_data_Two   <= '0;
      weight_data_Three <= '0;
      load_done         <= 1'b0;
    end else begin
      weight_wr <= accept ? (KERNEL_NUM'(1) << k) : '0;
      load_done <= last_beat;
      if (accept) begin
        weight_addra <= wa;
        if (k < 4'd3) begin
          weight_data_One <= s_data;
        end else if (k < 4'd6) begin
          weight_data_Two <= s_data;
        end else begin
          weight_data_Three <= s_data;
        end
      end
    end
  end

  // Read-issue flag delayed to line up with RAM output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_weight_3_3_load_ctrl.sv
// Self-checking bench for weight_3_3_load_ctrl: a per-job timeline model built
// from beat/issue arithmetic, a per-cycle compare process, and literal pins.
module tb_weight_3_3_load_ctrl;

  localparam int KN   = 9;
  localparam int AW   = 13;
  localparam int DW   = 128;
  localparam int LAT  = 2;
  localparam int MAXC = 128;

  logic          clk;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] cfg_load_words;
  logic [AW-1:0] cfg_read_len;
  logic [7:0]    cfg_read_passes;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] weight_data_One;
  logic [DW-1:0] weight_data_Two;
  logic [DW-1:0] weight_data_Three;
  logic [KN-1:0] weight_wr;
  logic [AW-1:0] weight_addra;
  logic [AW-1:0] weight_addrb;
  logic          rd_valid;
  logic          busy;
  logic          load_done;
  logic          done;

  weight_3_3_load_ctrl #(
    .KERNEL_NUM(KN),
    .WIDTH_RAM_ADDR_SIZE(AW),
    .DATA_W(DW),
    .RAM_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_start(cfg_start),
    .cfg_load_words(cfg_load_words),
    .cfg_read_len(cfg_read_len),
    .cfg_read_passes(cfg_read_passes),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .weight_data_One(weight_data_One),
    .weight_data_Two(weight_data_Two),
    .weight_data_Three(weight_data_Three),
    .weight_wr(weight_wr),
    .weight_addra(weight_addra),
    .weight_addrb(weight_addrb),
    .rd_valid(rd_valid),
    .busy(busy),
    .load_done(load_done),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int off    = 0;
  int chk_lim = 0;
  logic chk_on = 1'b0;

  // Expected per-cycle timeline of the current job, indexed by offset from cfg_start
  logic          e_ready [MAXC];
  logic [KN-1:0] e_wr    [MAXC];
  logic [AW-1:0] e_addra [MAXC];
  logic [AW-1:0] e_addrb [MAXC];
  logic          e_rdv   [MAXC];
  logic          e_busy  [MAXC];
  logic          e_ld    [MAXC];
  logic          e_done  [MAXC];
  logic [DW-1:0] e_l1    [MAXC];
  logic [DW-1:0] e_l2    [MAXC];
  logic [DW-1:0] e_l3    [MAXC];
  int            upd_lane[MAXC];
  logic [DW-1:0] upd_dat [MAXC];
  logic [DW-1:0] m1, m2, m3;

  // Observations of the DUT used by the literal pins
  int first_ld, first_done, n_wr, n_rdv;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s off=%0d actual=%0h required=%0h", name, off, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int job, input int o);
    return {32'(job), 32'(o), 32'hC0DE0000 | 32'(o), ~32'(o)};
  endfunction

  function automatic logic vld(input int vmode, input int o);
    return (vmode == 0) ? 1'b1 : o[0];
  endfunction

  // Build the expected timeline from the job's cfg and s_valid pattern; returns FIN offset
  task automatic build_model(input int lw, input int len, input int passes, input int vmode,
                             input int job, output int fin);
    int n, g, j, nrd;
    logic [DW-1:0] c1, c2, c3;
    for (int i = 0; i < MAXC; i++) begin
      e_ready[i] = 1'b0; e_wr[i] = '0; e_addra[i] = '0; e_addrb[i] = '0;
      e_rdv[i] = 1'b0; e_busy[i] = 1'b0; e_ld[i] = 1'b0; e_done[i] = 1'b0;
      upd_lane[i] = -1; upd_dat[i] = '0;
    end
    n = 0;
    if (lw == 0) begin
      g = 1;
    end else begin
      j = 1;
      g = 0;
      while (g == 0) begin
        e_ready[j] = 1'b1;
        if (vld(vmode, j)) begin
          e_wr[j+1]     = KN'(1) << (n % 9);
          e_addra[j+1]  = AW'(n / 9);
          upd_lane[j+1] = (n % 9) / 3;
          upd_dat[j+1]  = dat(job, j);
          n++;
          if (n == 9 * lw) begin
            e_ld[j+1] = 1'b1;
            g = j + 1;
          end
        end
        j++;
      end
    end
    if (len == 0 || passes == 0) begin
      fin = g + 1;
    end else begin
      nrd = len * passes;
      for (int i = 0; i < nrd; i++) begin
        e_addrb[g+1+i]   = AW'(i % len);
        e_rdv[g+1+i+LAT] = 1'b1;
      end
      fin = g + 1 + nrd + LAT;
    end
    for (int i = 1; i <= fin; i++) e_busy[i] = 1'b1;
    e_done[fin] = 1'b1;
    c1 = m1; c2 = m2; c3 = m3;
    for (int i = 0; i < MAXC; i++) begin
      if (upd_lane[i] == 0) c1 = upd_dat[i];
      if (upd_lane[i] == 1) c2 = upd_dat[i];
      if (upd_lane[i] == 2) c3 = upd_dat[i];
      e_l1[i] = c1; e_l2[i] = c2; e_l3[i] = c3;
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_on && off < chk_lim) begin
      cmp("s_ready", DW'(s_ready), DW'(e_ready[off]));
      cmp("weight_wr", DW'(weight_wr), DW'(e_wr[off]));
      if (e_wr[off] != '0) cmp("weight_addra", DW'(weight_addra), DW'(e_addra[off]));
      cmp("weight_addrb", DW'(weight_addrb), DW'(e_addrb[off]));
      cmp("rd_valid", DW'(rd_valid), DW'(e_rdv[off]));
      cmp("busy", DW'(busy), DW'(e_busy[off]));
      cmp("load_done", DW'(load_done), DW'(e_ld[off]));
      cmp("done", DW'(done), DW'(e_done[off]));
      cmp("lane_One", weight_data_One, e_l1[off]);
      cmp("lane_Two", weight_data_Two, e_l2[off]);
      cmp("lane_Three", weight_data_Three, e_l3[off]);
      if (weight_wr != '0 && rd_valid) cmp("wr_rd_overlap", 128'd1, 128'd0);
      if (load_done && first_ld < 0) first_ld = off;
      if (done && first_done < 0) first_done = off;
      if (weight_wr != '0) n_wr++;
      if (rd_valid) n_rdv++;
    end
  end

  // Run one job; xstart is an extra (ignored) cfg_start offset, rst_off a mid-job reset offset
  task automatic run_job(input int lw, input int len, input int passes, input int vmode,
                         input int xstart, input int rst_off, input int job);
    int fin, ncyc;
    build_model(lw, len, passes, vmode, job, fin);
    ncyc    = (rst_off > 0) ? rst_off + 1 : fin + 3;
    chk_lim = (rst_off > 0) ? rst_off : ncyc;
    first_ld = -1; first_done = -1; n_wr = 0; n_rdv = 0;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk);
      #1;
      off = j;
      chk_on = 1'b1;
      cfg_start = (j == 0) || (j == xstart);
      if (j == 0) begin
        cfg_load_words = AW'(lw); cfg_read_len = AW'(len); cfg_read_passes = 8'(passes);
      end else begin
        cfg_load_words = AW'(3); cfg_read_len = AW'(1); cfg_read_passes = 8'd1;
      end
      s_valid = vld(vmode, j);
      s_data  = dat(job, j);
      if (rst_off > 0 && j == rst_off) begin
        rst_n = 1'b0;
        #1;
        cmp("rst_s_ready", DW'(s_ready), '0);
        cmp("rst_weight_wr", DW'(weight_wr), '0);
        cmp("rst_weight_addra", DW'(weight_addra), '0);
        cmp("rst_weight_addrb", DW'(weight_addrb), '0);
        cmp("rst_rd_valid", DW'(rd_valid), '0);
        cmp("rst_busy", DW'(busy), '0);
        cmp("rst_load_done", DW'(load_done), '0);
        cmp("rst_done", DW'(done), '0);
        cmp("rst_lane_Two", weight_data_Two, '0);
        cmp("rst_lane_One", weight_data_One, '0);
      end
    end
    @(posedge clk);
    #1;
    chk_on = 1'b0;
    cfg_start = 1'b0;
    s_valid = 1'b0;
    if (rst_off > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      m1 = '0; m2 = '0; m3 = '0;
    end else begin
      m1 = e_l1[MAXC-1]; m2 = e_l2[MAXC-1]; m3 = e_l3[MAXC-1];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_load_words = '0; cfg_read_len = '0; cfg_read_passes = '0;
    s_data = '0; s_valid = 1'b0;
    m1 = '0; m2 = '0; m3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_busy", DW'(busy), '0);
    cmp("reset_s_ready", DW'(s_ready), '0);
    cmp("reset_weight_wr", DW'(weight_wr), '0);
    cmp("reset_lane_Three", weight_data_Three, '0);
    rst_n = 1'b1;

    // One word per RAM, single read
    run_job(1, 1, 1, 0, -1, 0, 1);
    cmp("t1_load_done_off", DW'(first_ld), DW'(10));
    cmp("t1_done_off", DW'(first_done), DW'(14));
    cmp("t1_writes", DW'(n_wr), DW'(9));
    cmp("t1_rd_valid", DW'(n_rdv), DW'(1));
    cmp("t1_lane_Three", weight_data_Three, dat(1, 9));

    // Two words per RAM with s_valid toggling
    run_job(2, 2, 1, 1, -1, 0, 2);
    cmp("t2_load_done_off", DW'(first_ld), DW'(36));
    cmp("t2_done_off", DW'(first_done), DW'(41));
    cmp("t2_writes", DW'(n_wr), DW'(18));

    // No load, 4x3 reads, stray cfg_start during READ
    run_job(0, 4, 3, 0, 5, 0, 3);
    cmp("t3_done_off", DW'(first_done), DW'(16));
    cmp("t3_rd_valid", DW'(n_rdv), DW'(12));
    cmp("t3_writes", DW'(n_wr), DW'(0));

    // Zero read length: load then straight to FIN
    run_job(1, 0, 2, 0, -1, 0, 4);
    cmp("t4_load_done_off", DW'(first_ld), DW'(10));
    cmp("t4_done_off", DW'(first_done), DW'(11));
    cmp("t4_rd_valid", DW'(n_rdv), DW'(0));

    // Reset mid-LOAD, then a fresh job from k=0, wa=0
    run_job(1, 1, 1, 0, -1, 7, 5);
    run_job(1, 1, 1, 0, -1, 0, 6);
    cmp("t6_done_off", DW'(first_done), DW'(14));
    cmp("t6_writes", DW'(n_wr), DW'(9));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
